// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine
//
// Initiator-side sequencer for the stacked register file. It moves a register
// context between the regfile and a context memory. Registers
// FIRST_REG..NUM_REGS-1 are transferred, so x0 is never touched.
//
// Save: the engine reads each register through read port A and sends it out
// on the save stream. Restore: the engine takes words from the restore stream
// and writes them into the regfile.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high. Once o_s_valid is raised it stays high
// until the beat transfers, and o_s_data/o_s_idx do not change while it is
// stalled. o_l_ready is high for the whole RESTORE state.
//
// Optional feature: when the macro REGFILE_CTX_CHECKSUM_EN is defined, the
// engine keeps a running XOR of the transferred words (o_checksum). At the end
// of a restore it compares that value with i_checksum and raises o_chk_err.
//
// Ports:
//   i_clk, i_reset_n             clock (rising edge), asynchronous active-low reset
//   i_save_req, i_restore_req    start requests, sampled only in IDLE (save wins)
//   o_busy, o_done               busy in SAVE/RESTORE; one-cycle pulse in DONE
//   o_rf_a_addr, i_rf_a_data     regfile read port A (data is combinational)
//   o_rf_w_ena/addr/data         regfile write port
//   o_s_valid, i_s_ready         save stream handshake
//   o_s_data, o_s_idx            save stream data and its register index
//   i_l_valid, o_l_ready         restore stream handshake
//   i_l_data                     restore stream data
//   o_checksum, i_checksum,      only with REGFILE_CTX_CHECKSUM_EN
//   o_chk_err
//   dbg_state                    current FSM state, for debug and checkers
module regfile_ctx_engine #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_save_req,
  input  logic                  i_restore_req,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rf_a_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_a_data,
  output logic                  o_rf_w_ena,
  output logic [ADDR_WIDTH-1:0] o_rf_w_addr,
  output logic [DATA_WIDTH-1:0] o_rf_w_data,
  output logic                  o_s_valid,
  input  logic                  i_s_ready,
  output logic [DATA_WIDTH-1:0] o_s_data,
  output logic [ADDR_WIDTH-1:0] o_s_idx,
  input  logic                  i_l_valid,
  output logic                  o_l_ready,
  input  logic [DATA_WIDTH-1:0] i_l_data,
`ifdef REGFILE_CTX_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] o_checksum,
  input  logic [DATA_WIDTH-1:0] i_checksum,
  output logic                  o_chk_err,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  s_beat;
  logic                  l_beat;

  // o_s_valid and o_l_ready are registered flags that are high exactly in
  // SAVE and RESTORE. Beats are qualified with these flags directly.
  assign s_beat = o_s_valid & i_s_ready;
  assign l_beat = o_l_ready & i_l_valid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= FIRST_IDX;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_s_valid <= 1'b0;
      o_l_ready <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= FIRST_IDX;
          if (i_save_req) begin
            state     <= SAVE;
            o_busy    <= 1'b1;
            o_s_valid <= 1'b1;
          end else if (i_restore_req) begin
            state     <= RESTORE;
            o_busy    <= 1'b1;
            o_l_ready <= 1'b1;
          end
        end
        SAVE: begin
          if (s_beat) begin
            if (cnt == LAST_IDX) begin
              state     <= DONE;
              o_busy    <= 1'b0;
              o_s_valid <= 1'b0;
              o_done    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESTORE: begin
          if (l_beat) begin
            if (cnt == LAST_IDX) begin
              state     <= DONE;
              o_busy    <= 1'b0;
              o_l_ready <= 1'b0;
              o_done    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // DONE: the o_done pulse is already showing. Any request seen here is dropped.
          state <= IDLE;
        end
      endcase
    end
  end

  // The address and data paths are gated by the state flags, so the ports read
  // zero outside the state that owns them. The save data passes straight from
  // the regfile read port to the stream, with no register in between.
  assign o_rf_a_addr = o_s_valid ? cnt : '0;
  assign o_s_idx     = o_s_valid ? cnt : '0;
  assign o_s_data    = o_s_valid ? i_rf_a_data : '0;
  assign o_rf_w_ena  = l_beat;
  assign o_rf_w_addr = o_l_ready ? cnt : '0;
  assign o_rf_w_data = o_l_ready ? i_l_data : '0;
  assign dbg_state   = state;

`ifdef REGFILE_CTX_CHECKSUM_EN
  // The XOR clears when a request is accepted. It then holds its value through
  // DONE and IDLE until the next transfer starts. The error flag is computed on
  // the final restore beat, so it is already high in the DONE cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_checksum <= '0;
      o_chk_err  <= 1'b0;
    end else if (state == IDLE && (i_save_req || i_restore_req)) begin
      o_checksum <= '0;
      o_chk_err  <= 1'b0;
    end else if (s_beat) begin
      o_checksum <= o_checksum ^ i_rf_a_data;
    end else if (l_beat) begin
      o_checksum <= o_checksum ^ i_l_data;
      if (cnt == LAST_IDX) begin
        o_chk_err <= ((o_checksum ^ i_l_data) != i_checksum);
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Testbench for regfile_ctx_engine.
// The bench contains a behavioural regfile that the DUT drives: read port A is
// combinational, and the write port commits on the clock edge. Stimulus pushes
// the expected save beats and regfile writes into queues. Two monitors pop
// those queues on the falling clock edge whenever the DUT presents a beat.
module tb_regfile_ctx_engine;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FR = 1;
  localparam int W  = AW + DW;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_save_req;
  logic          i_restore_req;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_rf_a_addr;
  logic [DW-1:0] i_rf_a_data;
  logic          o_rf_w_ena;
  logic [AW-1:0] o_rf_w_addr;
  logic [DW-1:0] o_rf_w_data;
  logic          o_s_valid;
  logic          i_s_ready;
  logic [DW-1:0] o_s_data;
  logic [AW-1:0] o_s_idx;
  logic          i_l_valid;
  logic          o_l_ready;
  logic [DW-1:0] i_l_data;
  logic [1:0]    dbg_state;
`ifdef REGFILE_CTX_CHECKSUM_EN
  logic [DW-1:0] o_checksum;
  logic [DW-1:0] i_checksum;
  logic          o_chk_err;
`endif

  regfile_ctx_engine #(
    .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_REG(FR)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_save_req(i_save_req), .i_restore_req(i_restore_req),
    .o_busy(o_busy), .o_done(o_done),
    .o_rf_a_addr(o_rf_a_addr), .i_rf_a_data(i_rf_a_data),
    .o_rf_w_ena(o_rf_w_ena), .o_rf_w_addr(o_rf_w_addr), .o_rf_w_data(o_rf_w_data),
    .o_s_valid(o_s_valid), .i_s_ready(i_s_ready),
    .o_s_data(o_s_data), .o_s_idx(o_s_idx),
    .i_l_valid(i_l_valid), .o_l_ready(o_l_ready), .i_l_data(i_l_data),
`ifdef REGFILE_CTX_CHECKSUM_EN
    .o_checksum(o_checksum), .i_checksum(i_checksum), .o_chk_err(o_chk_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- regfile model ----------------
  logic [DW-1:0] rf [NR];
  assign i_rf_a_data = rf[o_rf_a_addr];
  always @(posedge i_clk) begin
    if (o_rf_w_ena && o_rf_w_addr != '0) rf[o_rf_w_addr] <= o_rf_w_data;
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];   // expected save beats: {idx, data}
  logic [W-1:0] wexp_q[$];  // expected regfile writes: {addr, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Save monitor: a completing beat pops the queue. A stalled beat must already
  // show the head of the queue and keep it.
  always @(negedge i_clk) begin
    if (o_s_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL save_unexpected: got idx %0d data 0x%0h expected no beat", o_s_idx, o_s_data);
      end else if (i_s_ready) begin
        check("save_beat", 64'({o_s_idx, o_s_data}), 64'(exp_q.pop_front()));
      end else begin
        check("save_hold", 64'({o_s_idx, o_s_data}), 64'(exp_q[0]));
      end
    end
  end

  // Write monitor: every regfile write must match the head of the queue.
  always @(negedge i_clk) begin
    if (o_rf_w_ena) begin
      if (wexp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL write_unexpected: got addr %0d data 0x%0h expected no write", o_rf_w_addr, o_rf_w_data);
      end else begin
        check("rf_write", 64'({o_rf_w_addr, o_rf_w_data}), 64'(wexp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit bp_mode;      // save-side ready follows the pattern 1,0,0,1
  int l_mode;       // 0: restore stream idle, 1: gap every third cycle, 2: always valid
  int l_base;
  int ln;
  bit prev_lbeat;
  int pulse_at;     // iteration at which to pulse i_restore_req (-1 = never)

  task automatic start(input logic sv, input logic rs);
    @(posedge i_clk); #1;
    i_save_req    = sv;
    i_restore_req = rs;
    ln            = FR;
    prev_lbeat    = 1'b0;
  endtask

  task automatic run(input string tag, input int max_cyc, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge i_clk); #1;
      i_save_req    = 1'b0;
      i_restore_req = (k == pulse_at);
      i_s_ready     = bp_mode ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (l_mode != 0) begin
        if (prev_lbeat) ln++;
        i_l_valid = (l_mode == 1) ? (k % 3 != 2) : 1'b1;
        i_l_data  = DW'(l_base + ln);
      end
      @(negedge i_clk);
      prev_lbeat = i_l_valid && o_l_ready;
      cycles     = k + 1;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    64'(o_busy),      64'd0);
    check({tag, "_done"},    64'(o_done),      64'd0);
    check({tag, "_s_valid"}, 64'(o_s_valid),   64'd0);
    check({tag, "_l_ready"}, 64'(o_l_ready),   64'd0);
    check({tag, "_a_addr"},  64'(o_rf_a_addr), 64'd0);
    check({tag, "_w_ena"},   64'(o_rf_w_ena),  64'd0);
    check({tag, "_w_addr"},  64'(o_rf_w_addr), 64'd0);
    check({tag, "_w_data"},  64'(o_rf_w_data), 64'd0);
    check({tag, "_s_data"},  64'(o_s_data),    64'd0);
    check({tag, "_state"},   64'(dbg_state),   64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    int beats;
    logic [DW-1:0] xsum;

    for (int n = 0; n < NR; n++) rf[n] = DW'(n * 10);
    i_reset_n     = 1'b0;
    i_save_req    = 1'b0;
    i_restore_req = 1'b0;
    i_s_ready     = 1'b1;
    i_l_valid     = 1'b0;
    i_l_data      = '0;
    bp_mode       = 1'b0;
    l_mode        = 0;
    l_base        = 0;
    ln            = FR;
    prev_lbeat    = 1'b0;
    pulse_at      = -1;
`ifdef REGFILE_CTX_CHECKSUM_EN
    i_checksum    = '0;
`endif

    // Reset hold with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      i_save_req    = 1'($urandom_range(0, 1));
      i_restore_req = 1'($urandom_range(0, 1));
      i_s_ready     = 1'($urandom_range(0, 1));
      i_l_valid     = 1'($urandom_range(0, 1));
      i_l_data      = $urandom();
      @(negedge i_clk);
      check_all_zero("reset_hold");
    end
    @(posedge i_clk); #1;
    i_save_req    = 1'b0;
    i_restore_req = 1'b0;
    i_s_ready     = 1'b1;
    i_l_valid     = 1'b0;
    i_reset_n     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_w_ena", 64'(o_rf_w_ena), 64'd0);
    end

    // Save at full throughput: beats idx 1..31 with data 10..310, then DONE.
    for (int n = FR; n < NR; n++) exp_q.push_back({AW'(n), DW'(n * 10)});
    start(1'b1, 1'b0);
    run("save_full", 100, cyc);
    check("save_full_latency", 64'(cyc), 64'(NR - FR + 1));
    check("save_full_busy_in_done", 64'(o_busy), 64'd0);
    check("save_full_q_empty", 64'(exp_q.size()), 64'd0);
    // A request raised during DONE must be dropped.
    i_save_req = 1'b1;
    @(posedge i_clk); #1;
    i_save_req = 1'b0;
    @(negedge i_clk);
    check("done_req_ignored_busy", 64'(o_busy), 64'd0);
    check("done_req_ignored_done", 64'(o_done), 64'd0);
    check("done_req_ignored_state", 64'(dbg_state), 64'd0);

    // Save with backpressure: ready follows 1,0,0,1, so the last beat is at k=60.
    for (int n = FR; n < NR; n++) exp_q.push_back({AW'(n), DW'(n * 10)});
    bp_mode = 1'b1;
    start(1'b1, 1'b0);
    run("save_bp", 200, cyc);
    bp_mode = 1'b0;
    check("save_bp_latency", 64'(cyc), 64'd62);
    check("save_bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Restore with valid dropped on every third cycle: x1..x31 = 1001..1031.
    for (int n = FR; n < NR; n++) wexp_q.push_back({AW'(n), DW'(1000 + n)});
    l_mode = 1;
    l_base = 1000;
    start(1'b0, 1'b1);
    run("restore_gap", 200, cyc);
    l_mode    = 0;
    i_l_valid = 1'b0;
    check("restore_gap_latency", 64'(cyc), 64'd47);
    check("restore_gap_q_empty", 64'(wexp_q.size()), 64'd0);
    @(negedge i_clk);
    for (int n = 0; n < NR; n++)
      check($sformatf("restore_x%0d", n), 64'(rf[n]), (n == 0) ? 64'd0 : 64'(1000 + n));

    // Simultaneous requests: save wins, and a restore pulse during the save is ignored.
    for (int n = FR; n < NR; n++) exp_q.push_back({AW'(n), DW'(1000 + n)});
    pulse_at = 5;
    start(1'b1, 1'b1);
    run("both_req", 100, cyc);
    pulse_at = -1;
    check("both_req_latency", 64'(cyc), 64'(NR - FR + 1));
    check("both_req_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge i_clk);
    check("both_req_after_state", 64'(dbg_state), 64'd0);
    check("both_req_after_l_ready", 64'(o_l_ready), 64'd0);

    // Reset asserted after 5 restore beats.
    for (int n = FR; n < FR + 5; n++) wexp_q.push_back({AW'(n), DW'(2000 + n)});
    l_mode = 2;
    l_base = 2000;
    beats  = 0;
    start(1'b0, 1'b1);
    for (int k = 0; k < 20 && beats < 5; k++) begin
      @(posedge i_clk); #1;
      i_restore_req = 1'b0;
      if (prev_lbeat) ln++;
      i_l_valid = 1'b1;
      i_l_data  = DW'(l_base + ln);
      @(negedge i_clk);
      prev_lbeat = i_l_valid && o_l_ready;
      if (prev_lbeat) beats++;
    end
    check("midrst_beats", 64'(beats), 64'd5);
    @(posedge i_clk); #1;
    i_reset_n = 1'b0;
    #1;
    check_all_zero("midrst_immediate");
    i_l_valid = 1'b0;
    l_mode    = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("midrst_no_done", 64'(o_done), 64'd0);
    end
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("midrst_q_empty", 64'(wexp_q.size()), 64'd0);
    for (int n = 0; n < NR; n++)
      check($sformatf("midrst_x%0d", n), 64'(rf[n]),
            (n == 0) ? 64'd0 : (n <= 5) ? 64'(2000 + n) : 64'(1000 + n));

`ifdef REGFILE_CTX_CHECKSUM_EN
    // Restore with a wrong reference checksum: the error must show in DONE.
    xsum = '0;
    for (int n = FR; n < NR; n++) begin
      wexp_q.push_back({AW'(n), DW'(3000 + n)});
      xsum = xsum ^ DW'(3000 + n);
    end
    i_checksum = ~xsum;
    l_mode = 2;
    l_base = 3000;
    start(1'b0, 1'b1);
    run("chk", 100, cyc);
    l_mode    = 0;
    i_l_valid = 1'b0;
    check("chk_err_in_done", 64'(o_chk_err), 64'd1);
    check("chk_value", 64'(o_checksum), 64'(xsum));
    @(negedge i_clk);
    check("chk_err_sticky", 64'(o_chk_err), 64'd1);
    check("chk_value_held", 64'(o_checksum), 64'(xsum));
`else
    xsum = '0;
`endif

    repeat (3) @(negedge i_clk);
    check("end_save_q_empty", 64'(exp_q.size()), 64'd0);
    check("end_write_q_empty", 64'(wexp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_ctx_engine.md
Name: regfile_ctx_engine

Overview:
- Initiator-side sequencer for the stacked register file: drives its read-address and write ports to move a register context in or out.
- Save: reads registers FIRST_REG..NUM_REGS-1 through read port A and streams them out over a valid/ready interface towards the context memory.
- Restore: accepts a valid/ready stream and writes it back into the same register range.
- Sits between the interrupt/context controller and the regfile.

Parameters:
- NUM_REGS, 32, number of architectural registers
- ADDR_WIDTH, 5, register address width; NUM_REGS <= 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- FIRST_REG, 1, lowest register transferred (x0 is excluded); must be < NUM_REGS

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_save_req  in  1  start save; sampled in IDLE only
- i_restore_req  in  1  start restore; sampled in IDLE only
- o_busy  out  1  high in SAVE or RESTORE
- o_done  out  1  one-cycle pulse after the last transfer
- o_rf_a_addr  out  ADDR_WIDTH  regfile read port A address
- i_rf_a_data  in  DATA_WIDTH  regfile read port A data (combinational from address)
- o_rf_w_ena  out  1  regfile write enable
- o_rf_w_addr  out  ADDR_WIDTH  regfile write address
- o_rf_w_data  out  DATA_WIDTH  regfile write data
- o_s_valid  out  1  save stream valid
- i_s_ready  in  1  save stream ready
- o_s_data  out  DATA_WIDTH  save stream data
- o_s_idx  out  ADDR_WIDTH  register index of the current save beat
- i_l_valid  in  1  restore stream valid
- o_l_ready  out  1  restore stream ready
- i_l_data  in  DATA_WIDTH  restore stream data

Behaviour:
- Reset: async on i_reset_n low. State=IDLE, cnt=FIRST_REG. Every output is 0 (o_rf_a_addr=0, o_rf_w_ena=0, o_s_valid=0, o_l_ready=0, o_busy=0, o_done=0).
- States: IDLE, SAVE, RESTORE, DONE.
- IDLE: on i_save_req go to SAVE; else on i_restore_req go to RESTORE. If both requests are high, save wins and the restore request is dropped. cnt loads FIRST_REG.
- SAVE:
  - o_rf_a_addr=cnt, o_s_idx=cnt, o_s_valid=1.
  - o_s_data=i_rf_a_data, combinational with zero added latency.
  - Beat completes on o_s_valid & i_s_ready; then cnt++.
  - Beat with cnt==NUM_REGS-1 goes to DONE.
  - o_s_valid is never dropped while stalled; data and index are held stable under backpressure.
- RESTORE:
  - o_l_ready=1, o_rf_w_addr=cnt, o_rf_w_data=i_l_data.
  - o_rf_w_ena = i_l_valid & o_l_ready; the write commits at the regfile clock edge.
  - On a beat, cnt++. Beat with cnt==NUM_REGS-1 goes to DONE.
  - i_l_valid low means no write and cnt holds.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE. Requests arriving in DONE are ignored.
- Requests asserted during SAVE, RESTORE or DONE are ignored and not queued.
- Transfer count is always NUM_REGS-FIRST_REG beats. With full throughput the total time is (NUM_REGS-FIRST_REG) cycles plus 1 DONE cycle.
- Outside SAVE, o_rf_a_addr=0. Outside RESTORE, o_rf_w_ena=0, and o_rf_w_addr and o_rf_w_data are 0.
- Reset asserted mid-transfer: immediate abort to IDLE, no o_done, and no further writes. Registers already written remain written.
- cnt is ADDR_WIDTH bits and never increments past NUM_REGS-1.

Optional Feature:
- Macro REGFILE_CTX_CHECKSUM_EN.
- When defined:
  - Adds output o_checksum (DATA_WIDTH) and input i_checksum (DATA_WIDTH), plus output o_chk_err (1).
  - o_checksum is a running XOR of every transferred word, in either direction. It clears on leaving IDLE.
  - o_checksum is held after DONE until the next transfer starts.
  - At the end of a restore, o_chk_err is asserted in the DONE cycle if the final XOR differs from i_checksum.
  - o_chk_err is sticky until the next request is accepted. Reset clears all of these to 0.
- When undefined: these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset hold: i_reset_n=0 with random inputs -> all outputs 0, o_busy=0; release, idle 2 cycles -> no rf writes.
- Save, full throughput: regfile preloaded with x[n]=n*10, i_s_ready=1, pulse i_save_req -> 31 beats, idx 1..31, data 10..310, then o_done one cycle after beat idx 31.
- Save with backpressure: i_s_ready toggles 1,0,0,1 -> o_s_data/o_s_idx held while stalled, no beat lost or duplicated, still 31 beats.
- Restore with gaps: stream 1000+n, i_l_valid low on every third cycle -> o_rf_w_ena only on valid cycles, x1..x31=1001..1031, x0 untouched and reads 0.
- Simultaneous requests: i_save_req=i_restore_req=1 in IDLE -> SAVE entered, no writes; a restore request mid-save is ignored.
- Reset mid-restore: assert i_reset_n=0 after 5 beats -> outputs 0 immediately, x1..x5 written, x6..x31 unchanged, no o_done. With REGFILE_CTX_CHECKSUM_EN: wrong i_checksum -> o_chk_err=1 in DONE.
